// File: rtl/segment_scan_controller_pkg.sv
// ---------------------------------------------------------------------------
// segment_scan_controller_pkg
// Shared definitions for the multiplexed segment-display driver and for the
// logic that produces its display content.
//   POL_ACTIVE_HIGH / POL_ACTIVE_LOW : polarity values for the *_ACTIVE_LOW
//                                      parameters
//   cnt_width()                      : counter width for a 0..n-1 range
//                                      (never below 1 bit)
//   hex_to_seg7()                    : standard gfedcba encoding of a hex
//                                      nibble, bit 0 = segment a
// ---------------------------------------------------------------------------
package segment_scan_controller_pkg;

   localparam bit POL_ACTIVE_HIGH = 1'b0;
   localparam bit POL_ACTIVE_LOW  = 1'b1;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/segment_scan_controller_if.sv
// ---------------------------------------------------------------------------
// segment_scan_controller_if
// Bundles the content-side inputs and pin-side outputs of the scanner.
//   seg_data       : digit i at [i*SEG_WIDTH +: SEG_WIDTH], 1 = lit
//   digit_enable   : 1 = digit displayed
//   brightness     : 0 = dimmest, all-ones = brightest
//   update         : commit request for the three inputs above
//   update_ack     : one-cycle pulse, commit performed
//   segment_select : digit select pins (polarity set by the driver)
//   segments       : segment pins (polarity set by the driver)
//   frame_start    : one-cycle pulse on the first output cycle of digit 0
// master = content producer, slave = scanner.
// ---------------------------------------------------------------------------
interface segment_scan_controller_if #(
   parameter int NUM_DIGITS  = 4,
   parameter int SEG_WIDTH   = 8,
   parameter int BRIGHT_BITS = 4
);
   import segment_scan_controller_pkg::*;

   logic [NUM_DIGITS*SEG_WIDTH-1:0] seg_data;
   logic [NUM_DIGITS-1:0]           digit_enable;
   logic [BRIGHT_BITS-1:0]          brightness;
   logic                            update;
   logic                            update_ack;
   logic [NUM_DIGITS-1:0]           segment_select;
   logic [SEG_WIDTH-1:0]            segments;
   logic                            frame_start;

   modport master (
      output seg_data, digit_enable, brightness, update,
      input  update_ack, segment_select, segments, frame_start
   );

   modport slave (
      input  seg_data, digit_enable, brightness, update,
      output update_ack, segment_select, segments, frame_start
   );

endinterface

// File: rtl/segment_scan_controller_scan_slot_timer.sv
// ---------------------------------------------------------------------------
// scan_slot_timer
// Free-running slot/digit counters for the display scanner.
//   clk, rst     : clock, synchronous active-high reset
//   slot_cnt_o   : cycle within the current digit slot, 0..CLK_DIV-1
//   idx_o        : digit currently scanned, 0..NUM_DIGITS-1
//   slot_end_o   : last cycle of the current slot
//   frame_end_o  : last cycle of the last digit's slot (frame boundary)
// ---------------------------------------------------------------------------
module scan_slot_timer
   import segment_scan_controller_pkg::*;
#(
   parameter  int CLK_DIV    = 25000,
   parameter  int NUM_DIGITS = 4,
   localparam int CNT_W      = cnt_width(CLK_DIV),
   localparam int IDX_W      = cnt_width(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] slot_cnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             slot_end_o,
   output logic             frame_end_o
);

   logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   assign slot_end_o  = (slot_cnt_q == CNT_W'(CLK_DIV - 1));
   assign frame_end_o = slot_end_o && (idx_q == IDX_W'(NUM_DIGITS - 1));

   // NOTE: every variable gets its hold value first so no path leaves it
   // unassigned; that is what keeps always_comb free of latches.
   always_comb begin
      slot_cnt_d = slot_cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (slot_end_o) begin
         slot_cnt_d = '0;
         idx_d      = frame_end_o ? '0 : idx_q + IDX_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q <= '0;
         idx_q      <= '0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         idx_q      <= idx_d;
      end
   end

   assign slot_cnt_o = slot_cnt_q;
   assign idx_o      = idx_q;

endmodule

// File: rtl/segment_scan_controller.sv
// ---------------------------------------------------------------------------
// segment_scan_controller
// Time-multiplexed driver for multi-digit segment displays with blanking,
// PWM brightness, per-digit enable and frame-synchronous double buffering.
//   clk, rst : clock, synchronous active-high reset
//   bus      : segment_scan_controller_if slave (content inputs, update
//              handshake, select/segment pins, frame_start)
// All pin outputs are registered; they reflect the counter state one cycle
// earlier.
// ---------------------------------------------------------------------------
module segment_scan_controller
   import segment_scan_controller_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SEG_WIDTH      = 8,
   parameter int CLK_DIV        = 25000,
   parameter int BLANK_CYCLES   = 500,
   parameter int BRIGHT_BITS    = 4,
   parameter bit SEL_ACTIVE_LOW = POL_ACTIVE_LOW,
   parameter bit SEG_ACTIVE_LOW = POL_ACTIVE_HIGH
) (
   input logic                      clk,
   input logic                      rst,
   segment_scan_controller_if.slave bus
);

   localparam int CNT_W = cnt_width(CLK_DIV);
   localparam int IDX_W = cnt_width(NUM_DIGITS);
   // Lit time per brightness step, taken from the non-blanked part of a slot.
   localparam int STEP  = (CLK_DIV - BLANK_CYCLES) >> BRIGHT_BITS;

   // XOR masks: inactive pin levels, also used to apply output polarity.
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [SEG_WIDTH-1:0]  SEG_OFF = {SEG_WIDTH{SEG_ACTIVE_LOW}};

   if (NUM_DIGITS < 1) begin : g_err_digits
      $error("segment_scan_controller: NUM_DIGITS must be >= 1");
   end
   if (BLANK_CYCLES >= CLK_DIV) begin : g_err_blank
      $error("segment_scan_controller: BLANK_CYCLES must be < CLK_DIV");
   end
   if (STEP < 1) begin : g_err_step
      $error("segment_scan_controller: brightness STEP evaluates below 1");
   end

   logic [CNT_W-1:0] slot_cnt;
   logic [IDX_W-1:0] idx;
   logic             slot_end;
   logic             frame_end;

   scan_slot_timer #(
      .CLK_DIV    (CLK_DIV),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .slot_cnt_o  (slot_cnt),
      .idx_o       (idx),
      .slot_end_o  (slot_end),
      .frame_end_o (frame_end)
   );

   // Shadow (displayed) copies of the content inputs.
   logic [NUM_DIGITS-1:0][SEG_WIDTH-1:0] seg_l_q, seg_l_d;
   logic [NUM_DIGITS-1:0]                en_l_q, en_l_d;
   logic [BRIGHT_BITS-1:0]               bright_l_q, bright_l_d;
   logic                                 pending_q, pending_d;

   logic                  update_ack_q, update_ack_d;
   logic                  frame_start_q, frame_start_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [SEG_WIDTH-1:0]  segs_q, segs_d;

   logic                  commit;
   logic                  lit;
   int                    slot_i;
   int                    on_len;
   logic [NUM_DIGITS-1:0] sel_onehot;
   logic [SEG_WIDTH-1:0]  segs_raw;

   // frame_end already implies slot_end; both are spelled out so the commit
   // point reads as "last cycle of the last slot". An update arriving on that
   // very cycle is honoured without first going through pending.
   assign commit = slot_end && frame_end && (pending_q || bus.update);

   always_comb begin
      seg_l_d      = seg_l_q;
      en_l_d       = en_l_q;
      bright_l_d   = bright_l_q;
      pending_d    = pending_q || bus.update;
      update_ack_d = 1'b0;
      if (commit) begin
         seg_l_d      = bus.seg_data;
         en_l_d       = bus.digit_enable;
         bright_l_d   = bus.brightness;
         pending_d    = 1'b0;
         update_ack_d = 1'b1;
      end

      // Leading BLANK_CYCLES of every slot are dark (anti-ghosting); after
      // that the digit stays lit for (brightness+1)*STEP cycles.
      slot_i = int'(slot_cnt);
      on_len = (int'(bright_l_q) + 1) * STEP;
      lit    = en_l_q[idx] && (slot_i >= BLANK_CYCLES)
               && ((slot_i - BLANK_CYCLES) < on_len);

      sel_onehot = '0;
      segs_raw   = '0;
      if (lit) begin
         sel_onehot[idx] = 1'b1;
         segs_raw        = seg_l_q[idx];
      end
      sel_d  = sel_onehot ^ SEL_OFF;
      segs_d = segs_raw ^ SEG_OFF;

      frame_start_d = (idx == '0) && (slot_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow registers are reset even though they are data
         // storage; the display must stay dark until the first commit.
         seg_l_q       <= '0;
         en_l_q        <= '0;
         bright_l_q    <= '0;
         pending_q     <= 1'b0;
         update_ack_q  <= 1'b0;
         frame_start_q <= 1'b0;
         sel_q         <= SEL_OFF;
         segs_q        <= SEG_OFF;
      end else begin
         seg_l_q       <= seg_l_d;
         en_l_q        <= en_l_d;
         bright_l_q    <= bright_l_d;
         pending_q     <= pending_d;
         update_ack_q  <= update_ack_d;
         frame_start_q <= frame_start_d;
         sel_q         <= sel_d;
         segs_q        <= segs_d;
      end
   end

   assign bus.update_ack     = update_ack_q;
   assign bus.frame_start    = frame_start_q;
   assign bus.segment_select = sel_q;
   assign bus.segments       = segs_q;

endmodule

// File: tb/tb_segment_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_segment_scan_controller
// Scoreboard bench: a reference model, evaluated once per clock edge from the
// display rules (time since reset, shadow contents), pushes the expected pin
// state into a queue; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_segment_scan_controller;
   import segment_scan_controller_pkg::*;

   localparam int N     = 4;
   localparam int SW    = 8;
   localparam int CD    = 20;
   localparam int BL    = 4;
   localparam int BB    = 2;
   localparam int STEP  = (CD - BL) >> BB;
   localparam int FRAME = CD * N;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   segment_scan_controller_if #(
      .NUM_DIGITS  (N),
      .SEG_WIDTH   (SW),
      .BRIGHT_BITS (BB)
   ) bus ();

   segment_scan_controller #(
      .NUM_DIGITS     (N),
      .SEG_WIDTH      (SW),
      .CLK_DIV        (CD),
      .BLANK_CYCLES   (BL),
      .BRIGHT_BITS    (BB),
      .SEL_ACTIVE_LOW (1'b1),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [N-1:0]  sel;
      logic [SW-1:0] seg;
      logic          fs;
      logic          ack;
   } out_t;

   out_t exp_q[$];

   int pass_cnt  = 0;
   int check_cnt = 0;
   int ack_seen  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // m_t counts edges since reset release: it is the position in the scan
   // that the design is in when the next edge arrives.
   int         m_t;
   logic [7:0] m_seg[N];
   bit         m_en[N];
   int         m_bright;
   bit         m_pend;

   initial begin : model
      out_t e;
      int   slot, dig;
      bit   lit, boundary;
      forever begin
         @(posedge clk);
         if (rst) begin
            e = '{sel: {N{1'b1}}, seg: '0, fs: 1'b0, ack: 1'b0};
            m_t = 0;
            m_pend = 1'b0;
            m_bright = 0;
            for (int i = 0; i < N; i++) begin
               m_seg[i] = '0;
               m_en[i]  = 1'b0;
            end
         end else begin
            slot     = m_t % CD;
            dig      = (m_t / CD) % N;
            boundary = (m_t % FRAME) == FRAME - 1;
            lit      = m_en[dig] && slot >= BL && (slot - BL) < (m_bright + 1) * STEP;
            for (int i = 0; i < N; i++) e.sel[i] = !(lit && i == dig);
            e.seg = lit ? m_seg[dig] : 8'h00;
            e.fs  = (m_t % FRAME) == 0;
            e.ack = boundary && (m_pend || bus.update);
            m_pend = m_pend || bus.update;
            if (e.ack) begin
               for (int i = 0; i < N; i++) begin
                  m_seg[i] = bus.seg_data[i*SW +: SW];
                  m_en[i]  = bus.digit_enable[i];
               end
               m_bright = int'(bus.brightness);
               m_pend   = 1'b0;
            end
            m_t++;
         end
         exp_q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      out_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("segment_select", 32'(bus.segment_select), 32'(e.sel));
            check("segments", 32'(bus.segments), 32'(e.seg));
            check("frame_start", 32'(bus.frame_start), 32'(e.fs));
            check("update_ack", 32'(bus.update_ack), 32'(e.ack));
            if (bus.update_ack === 1'b1) ack_seen++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_phase(input int ph);
      int n = 0;
      while ((m_t % FRAME) != ph && n < 2 * FRAME) begin
         tick();
         n++;
      end
   endtask

   task automatic load(input logic [N*SW-1:0] seg, input logic [N-1:0] en, input int br);
      bus.seg_data     = seg;
      bus.digit_enable = en;
      bus.brightness   = BB'(br);
   endtask

   task automatic pulse_update();
      bus.update = 1'b1;
      tick();
      bus.update = 1'b0;
   endtask

   task automatic wait_ack(input string name);
      int n = 0;
      while (bus.update_ack !== 1'b1 && n < 2 * FRAME) begin
         tick();
         n++;
      end
      check(name, 32'(bus.update_ack), 32'd1);
   endtask

   function automatic logic [N*SW-1:0] rand_digits();
      logic [N*SW-1:0] v;
      for (int i = 0; i < N; i++)
         v[i*SW +: SW] = {1'($urandom_range(0, 1)), hex_to_seg7(4'($urandom_range(0, 15)))};
      return v;
   endfunction

   localparam logic [N*SW-1:0] DIGITS_0123 = 32'h4F5B063F;

   initial begin : stim
      int a0;
      bus.seg_data     = '0;
      bus.digit_enable = '0;
      bus.brightness   = '0;
      bus.update       = 1'b0;
      rst              = 1'b1;
      repeat (3) tick();
      check("rst_select", 32'(bus.segment_select), 32'hF);
      check("rst_segments", 32'(bus.segments), 32'h0);
      check("rst_ack", 32'(bus.update_ack), 32'h0);
      rst = 1'b0;
      repeat (FRAME + 5) tick();

      // Full brightness, then brightness 0 and 2, then partial enable.
      load(DIGITS_0123, 4'b1111, 3);
      pulse_update();
      wait_ack("ack_full");
      repeat (FRAME + 2) tick();
      load(DIGITS_0123, 4'b1111, 0);
      pulse_update();
      wait_ack("ack_bright0");
      repeat (FRAME + 2) tick();
      load(DIGITS_0123, 4'b1111, 2);
      pulse_update();
      wait_ack("ack_bright2");
      repeat (FRAME + 2) tick();
      load(DIGITS_0123, 4'b0101, 3);
      pulse_update();
      wait_ack("ack_enable");
      repeat (FRAME + 2) tick();

      // Input change without update must not reach the pins.
      load(rand_digits(), 4'b1111, 1);
      repeat (FRAME + 7) tick();

      // Two updates mid-frame merge into one commit / one ack.
      load(rand_digits(), 4'b1011, 3);
      goto_phase(30);
      a0 = ack_seen;
      pulse_update();
      goto_phase(50);
      pulse_update();
      wait_ack("ack_merge");
      repeat (FRAME) tick();
      check("merge_one_ack", 32'(ack_seen - a0), 32'd1);

      // Update raised exactly on the boundary cycle commits at that boundary.
      load(rand_digits(), 4'b1111, 3);
      goto_phase(FRAME - 1);
      pulse_update();
      check("ack_on_boundary", 32'(bus.update_ack), 32'd1);
      repeat (FRAME + 3) tick();

      // Reset with a pending update: no ack, dark outputs, restart at digit 0.
      load(rand_digits(), 4'b1111, 2);
      goto_phase(30);
      pulse_update();
      goto_phase(50);
      a0  = ack_seen;
      rst = 1'b1;
      tick();
      check("rst_mid_select", 32'(bus.segment_select), 32'hF);
      check("rst_mid_segments", 32'(bus.segments), 32'h0);
      tick();
      rst = 1'b0;
      repeat (2 * FRAME) tick();
      check("no_ack_after_rst", 32'(ack_seen - a0), 32'd0);

      // Randomized commits, scrambled inputs between them, one random reset.
      for (int k = 0; k < 8; k++) begin
         load(rand_digits(), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
         goto_phase($urandom_range(0, FRAME - 1));
         pulse_update();
         if ($urandom_range(0, 1) == 1) pulse_update();
         wait_ack("ack_random");
         repeat (2) tick();
         load(rand_digits(), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
         repeat ($urandom_range(FRAME, 2 * FRAME)) tick();
         if (k == 5) begin
            rst = 1'b1;
            repeat (2) tick();
            rst = 1'b0;
            repeat (FRAME / 2) tick();
         end
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
